// File: rtl/axi_mst_wr_gen.sv
// axi_mst_wr_gen: AXI3 write-traffic master for crossbar bring-up.
// Issues AW bursts with accumulating INCR addresses and streams the matching
// W beats with Galois-LFSR data. Outstanding writes are tracked until their
// B responses return.
// Optional build macro AXI_MST_WR_GEN_BCHK_EN adds an expected-ID FIFO that
// checks every B response (bid/bresp) and counts mismatches in err_cnt.
module axi_mst_wr_gen #(
  parameter int unsigned           AXI_ADDR_W = 32,
  parameter int unsigned           AXI_ID_W   = 4,
  parameter int unsigned           AXI_DATA_W = 32,
  parameter int unsigned           OSTD_NUM   = 4,
  parameter logic [1:0]            MST_ID     = 2'b01,
  parameter logic [AXI_ADDR_W-1:0] BASE_ADDR  = '0,
  parameter logic [31:0]           LFSR_SEED  = 32'hACE1_0001
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          start,
  input  logic [3:0]                    cfg_len,
  input  logic [2:0]                    cfg_size,
  input  logic [15:0]                   cfg_num_req,
  output logic                          awvalid,
  input  logic                          awready,
  output logic [AXI_ADDR_W-1:0]         awaddr,
  output logic [3:0]                    awlen,
  output logic [2:0]                    awsize,
  output logic [1:0]                    awburst,
  output logic [AXI_ID_W-1:0]           awid,
  output logic [1:0]                    awlock,
  output logic                          wvalid,
  input  logic                          wready,
  output logic                          wlast,
  output logic [AXI_ID_W-1:0]           wid,
  output logic [AXI_DATA_W-1:0]         wdata,
  output logic [AXI_DATA_W/8-1:0]       wstrb,
  input  logic                          bvalid,
  output logic                          bready,
  input  logic [AXI_ID_W-1:0]           bid,
  input  logic [1:0]                    bresp,
  output logic [$clog2(OSTD_NUM):0]     ostd_cnt,
  output logic [15:0]                   req_cnt,
  output logic [15:0]                   resp_cnt,
  output logic [7:0]                    err_cnt,
  output logic                          done
);

  localparam int unsigned OSTD_W    = $clog2(OSTD_NUM);
  localparam int unsigned CNT_W     = OSTD_W + 1;
  localparam int unsigned SEQ_W     = AXI_ID_W - 2;
  localparam int unsigned DATA_REP  = AXI_DATA_W / 32;
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;  // x^32+x^22+x^2+x+1

  // One right-shifting Galois LFSR step.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    if (s[0]) begin
      return (s >> 1) ^ LFSR_MASK;
    end else begin
      return s >> 1;
    end
  endfunction

  typedef enum logic [0:0] {AW_IDLE = 1'b0, AW_REQ = 1'b1} aw_state_e;

  aw_state_e               aw_state_q, aw_state_d;
  logic [AXI_ADDR_W-1:0]   awaddr_q, awaddr_d, burst_bytes_s;
  logic [3:0]              awlen_q, awlen_d;
  logic [2:0]              awsize_q, awsize_d;
  logic [SEQ_W-1:0]        seq_q, seq_d;
  logic [15:0]             req_cnt_q, req_cnt_d, resp_cnt_q, resp_cnt_d;
  logic [CNT_W-1:0]        ostd_q, ostd_d;
  logic                    done_q, done_d;
  logic                    launch_ok_s;
  logic                    aw_hs, w_hs, b_hs, b_dec, wq_pop;
  logic [3:0]              wq_len_q [OSTD_NUM];
  logic [AXI_ID_W-1:0]     wq_id_q  [OSTD_NUM];
  logic [OSTD_W-1:0]       wq_wptr_q, wq_wptr_d, wq_rptr_q, wq_rptr_d;
  logic [CNT_W-1:0]        wq_cnt_q, wq_cnt_d;
  logic [3:0]              beat_q, beat_d;
  logic [31:0]             lfsr_q, lfsr_d, brdy_lfsr_q, brdy_lfsr_d;
  logic                    bready_q;

  assign aw_hs  = awvalid & awready;
  assign w_hs   = wvalid & wready;
  assign b_hs   = bvalid & bready_q;
  assign b_dec  = b_hs & (ostd_q != '0);
  assign wq_pop = w_hs & wlast;

  assign awvalid  = (aw_state_q == AW_REQ);
  assign awaddr   = awaddr_q;
  assign awlen    = awlen_q;
  assign awsize   = awsize_q;
  assign awburst  = 2'b01;
  assign awlock   = 2'b00;
  assign awid     = {MST_ID, seq_q};
  assign wvalid   = (wq_cnt_q != '0);
  assign wid      = wq_id_q[wq_rptr_q];
  assign wlast    = wvalid & (beat_q == wq_len_q[wq_rptr_q]);
  assign wdata    = {DATA_REP{lfsr_q}};
  assign wstrb    = wvalid ? '1 : '0;
  assign bready   = bready_q;
  assign ostd_cnt = ostd_q;
  assign req_cnt  = req_cnt_q;
  assign resp_cnt = resp_cnt_q;
  assign done     = done_q;

  // Counters, W queue occupancy and the launch decision, all from next-state
  // values so a new AW can be launched in the same cycle as a handshake.
  always_comb begin
    req_cnt_d  = req_cnt_q;
    resp_cnt_d = resp_cnt_q;
    ostd_d     = ostd_q;
    wq_cnt_d   = wq_cnt_q;
    if (aw_hs) begin
      req_cnt_d = req_cnt_q + 16'd1;
    end else if (!start && (ostd_q == '0)) begin
      req_cnt_d = 16'd0;
    end else begin
      req_cnt_d = req_cnt_q;
    end
    if (b_hs) begin
      resp_cnt_d = resp_cnt_q + 16'd1;
    end else if (!start && (ostd_q == '0)) begin
      resp_cnt_d = 16'd0;
    end else begin
      resp_cnt_d = resp_cnt_q;
    end
    case ({aw_hs, b_dec})
      2'b10:   ostd_d = ostd_q + CNT_W'(1);
      2'b01:   ostd_d = ostd_q - CNT_W'(1);
      default: ostd_d = ostd_q;
    endcase
    case ({aw_hs, wq_pop})
      2'b10:   wq_cnt_d = wq_cnt_q + CNT_W'(1);
      2'b01:   wq_cnt_d = wq_cnt_q - CNT_W'(1);
      default: wq_cnt_d = wq_cnt_q;
    endcase
    launch_ok_s = start && (req_cnt_d < cfg_num_req) &&
                  (ostd_d < CNT_W'(OSTD_NUM)) && (wq_cnt_d < CNT_W'(OSTD_NUM));
    done_d      = start && (req_cnt_d == cfg_num_req) && (ostd_d == '0);
  end

  // Byte span of the burst currently on AW, used to advance the address.
  always_comb begin
    burst_bytes_s = AXI_ADDR_W'({1'b0, awlen_q} + 5'd1) << awsize_q;
  end

  // AW state machine: launch, hold request stable until awready, relaunch.
  always_comb begin
    aw_state_d = aw_state_q;
    awaddr_d   = awaddr_q;
    awlen_d    = awlen_q;
    awsize_d   = awsize_q;
    seq_d      = seq_q;
    case (aw_state_q)
      AW_IDLE: begin
        if (launch_ok_s) begin
          aw_state_d = AW_REQ;
          awlen_d    = cfg_len;
          awsize_d   = cfg_size;
        end else begin
          aw_state_d = AW_IDLE;
        end
      end
      AW_REQ: begin
        if (awready) begin
          awaddr_d = awaddr_q + burst_bytes_s;
          seq_d    = seq_q + SEQ_W'(1);
          if (launch_ok_s) begin
            aw_state_d = AW_REQ;
            awlen_d    = cfg_len;
            awsize_d   = cfg_size;
          end else begin
            aw_state_d = AW_IDLE;
          end
        end else begin
          aw_state_d = AW_REQ;
        end
      end
      default: aw_state_d = AW_IDLE;
    endcase
  end

  // W side next state: beat counter, queue pointers, data LFSR advance.
  // bready uses its own free-running LFSR so W data never skips a value.
  always_comb begin
    wq_wptr_d   = aw_hs ? wq_wptr_q + OSTD_W'(1) : wq_wptr_q;
    wq_rptr_d   = wq_pop ? wq_rptr_q + OSTD_W'(1) : wq_rptr_q;
    if (wq_pop) begin
      beat_d = 4'd0;
    end else if (w_hs) begin
      beat_d = beat_q + 4'd1;
    end else begin
      beat_d = beat_q;
    end
    lfsr_d      = w_hs ? lfsr_step(lfsr_q) : lfsr_q;
    brdy_lfsr_d = lfsr_step(brdy_lfsr_q);
  end

  // AW channel and counter registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_state_q <= AW_IDLE;
      awaddr_q   <= BASE_ADDR;
      awlen_q    <= 4'd0;
      awsize_q   <= 3'd0;
      seq_q      <= '0;
      req_cnt_q  <= 16'd0;
      resp_cnt_q <= 16'd0;
      ostd_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      aw_state_q <= aw_state_d;
      awaddr_q   <= awaddr_d;
      awlen_q    <= awlen_d;
      awsize_q   <= awsize_d;
      seq_q      <= seq_d;
      req_cnt_q  <= req_cnt_d;
      resp_cnt_q <= resp_cnt_d;
      ostd_q     <= ostd_d;
      done_q     <= done_d;
    end
  end

  // W queue storage, beat tracking, LFSRs and registered bready.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < OSTD_NUM; i++) begin
        wq_len_q[i] <= 4'd0;
        wq_id_q[i]  <= '0;
      end
      wq_wptr_q   <= '0;
      wq_rptr_q   <= '0;
      wq_cnt_q    <= '0;
      beat_q      <= 4'd0;
      lfsr_q      <= LFSR_SEED;
      brdy_lfsr_q <= LFSR_SEED;
      bready_q    <= 1'b0;
    end else begin
      if (aw_hs) begin
        wq_len_q[wq_wptr_q] <= awlen_q;
        wq_id_q[wq_wptr_q]  <= awid;
      end
      wq_wptr_q   <= wq_wptr_d;
      wq_rptr_q   <= wq_rptr_d;
      wq_cnt_q    <= wq_cnt_d;
      beat_q      <= beat_d;
      lfsr_q      <= lfsr_d;
      brdy_lfsr_q <= brdy_lfsr_d;
      bready_q    <= brdy_lfsr_q[7];
    end
  end

`ifdef AXI_MST_WR_GEN_BCHK_EN
  logic [AXI_ID_W-1:0] idf_q [OSTD_NUM];
  logic [OSTD_W-1:0]   idf_wptr_q, idf_wptr_d, idf_rptr_q, idf_rptr_d;
  logic [CNT_W-1:0]    idf_cnt_q, idf_cnt_d;
  logic                idf_empty_s, idf_pop_s, b_err_s;
  logic [7:0]          err_q, err_d;

  // Expected-ID FIFO bookkeeping and saturating B error counter.
  always_comb begin
    idf_empty_s = (idf_cnt_q == '0);
    idf_pop_s   = b_hs & ~idf_empty_s;
    idf_wptr_d  = aw_hs ? idf_wptr_q + OSTD_W'(1) : idf_wptr_q;
    idf_rptr_d  = idf_pop_s ? idf_rptr_q + OSTD_W'(1) : idf_rptr_q;
    case ({aw_hs, idf_pop_s})
      2'b10:   idf_cnt_d = idf_cnt_q + CNT_W'(1);
      2'b01:   idf_cnt_d = idf_cnt_q - CNT_W'(1);
      default: idf_cnt_d = idf_cnt_q;
    endcase
    b_err_s = b_hs & (idf_empty_s | (bid != idf_q[idf_rptr_q]) | (bresp != 2'b00));
    if (b_err_s && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end else begin
      err_d = err_q;
    end
  end

  // Expected-ID FIFO and error counter registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < OSTD_NUM; i++) begin
        idf_q[i] <= '0;
      end
      idf_wptr_q <= '0;
      idf_rptr_q <= '0;
      idf_cnt_q  <= '0;
      err_q      <= 8'd0;
    end else begin
      if (aw_hs) begin
        idf_q[idf_wptr_q] <= awid;
      end
      idf_wptr_q <= idf_wptr_d;
      idf_rptr_q <= idf_rptr_d;
      idf_cnt_q  <= idf_cnt_d;
      err_q      <= err_d;
    end
  end

  assign err_cnt = err_q;
`else
  logic bchk_unused_s;
  assign bchk_unused_s = ^{bid, bresp};
  assign err_cnt       = 8'd0;
`endif

endmodule

// File: tb/tb_axi_mst_wr_gen.sv
// Directed bench for axi_mst_wr_gen: acts as a simple AXI slave, models the
// expected AW/W/B streams and checks them with immediate assertions.
module tb_axi_mst_wr_gen;

  logic        aclk = 1'b0;
  logic        aresetn, start;
  logic [3:0]  cfg_len;
  logic [2:0]  cfg_size;
  logic [15:0] cfg_num_req;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [3:0]  awid;
  logic [1:0]  awlock;
  logic        wvalid, wready, wlast;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid, bready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic [2:0]  ostd_cnt;
  logic [15:0] req_cnt, resp_cnt;
  logic [7:0]  err_cnt;
  logic        done;

  int n_eval = 0;
  int n_fail = 0;

  logic [31:0] exp_addr, model_lfsr;
  int          exp_seq, beat, aw_seen, beats_seen, b_seen;
  int          wq_len[$];
  logic [3:0]  wq_id[$];
  logic [3:0]  bq[$];
  int          corrupt_q[$];

`ifdef AXI_MST_WR_GEN_BCHK_EN
  localparam int EXP_ERR = 2;
`else
  localparam int EXP_ERR = 0;
`endif

  axi_mst_wr_gen dut (
    .aclk(aclk), .aresetn(aresetn), .start(start),
    .cfg_len(cfg_len), .cfg_size(cfg_size), .cfg_num_req(cfg_num_req),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst), .awid(awid), .awlock(awlock),
    .wvalid(wvalid), .wready(wready), .wlast(wlast), .wid(wid),
    .wdata(wdata), .wstrb(wstrb), .bvalid(bvalid), .bready(bready),
    .bid(bid), .bresp(bresp), .ostd_cnt(ostd_cnt), .req_cnt(req_cnt),
    .resp_cnt(resp_cnt), .err_cnt(err_cnt), .done(done)
  );

  initial forever #5 aclk = ~aclk;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_eval++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_addr = 32'd0; model_lfsr = 32'hACE1_0001; exp_seq = 0; beat = 0;
    aw_seen = 0; beats_seen = 0; b_seen = 0;
    wq_len.delete(); wq_id.delete(); bq.delete(); corrupt_q.delete();
  endtask

  task automatic do_reset();
    aresetn = 1'b0; start = 1'b0; awready = 1'b0; wready = 1'b0;
    bvalid = 1'b0; bid = 4'd0; bresp = 2'b00;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    model_reset();
  endtask

  // One slave cycle per iteration; decisions and checks at the falling edge.
  task automatic run(input int max_cyc, input bit rand_w, input bit hold_b, input bit until_done);
    logic [3:0] eid;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge aclk);
      if (until_done && done) break;
      awready = 1'b1;
      wready  = rand_w ? 1'($urandom_range(0, 1)) : 1'b1;
      bvalid  = !hold_b && (bq.size() > 0);
      bid     = (bq.size() > 0) ? bq[0] : 4'd0;
      bresp   = 2'b00;
      if (bvalid && corrupt_q.size() > 0) begin
        if (corrupt_q[0] == 1) bid = 4'b0101;
        else if (corrupt_q[0] == 2) bresp = 2'b10;
      end
      if (bvalid && bready) begin
        void'(bq.pop_front());
        b_seen++;
        if (corrupt_q.size() > 0) void'(corrupt_q.pop_front());
      end
      if (wvalid) begin
        check("w_has_aw", 64'(wq_len.size() != 0), 64'd1);
        if (wq_len.size() != 0) begin
          check("wid", 64'(wid), 64'(wq_id[0]));
          check("wdata", 64'(wdata), 64'(model_lfsr));
          check("wstrb", 64'(wstrb), 64'h0F);
          check("wlast", 64'(wlast), 64'(beat == wq_len[0]));
          if (wready) begin
            model_lfsr = lfsr_next(model_lfsr);
            beats_seen++;
            if (beat == wq_len[0]) begin
              bq.push_back(wq_id[0]);
              void'(wq_len.pop_front());
              void'(wq_id.pop_front());
              beat = 0;
            end else begin
              beat++;
            end
          end
        end
      end
      if (awvalid) begin
        eid = {2'b01, 2'(exp_seq)};
        check("awaddr", 64'(awaddr), 64'(exp_addr));
        check("awid", 64'(awid), 64'(eid));
        check("awlen", 64'(awlen), 64'(cfg_len));
        check("awsize", 64'(awsize), 64'(cfg_size));
        check("awburst", 64'(awburst), 64'd1);
        wq_len.push_back(int'(cfg_len));
        wq_id.push_back(eid);
        exp_addr = exp_addr + ((32'(cfg_len) + 32'd1) << cfg_size);
        exp_seq++;
        aw_seen++;
      end
    end
    if (until_done) check("done_reached", 64'(done), 64'd1);
  endtask

  initial begin
    cfg_len = 4'd0; cfg_size = 3'd0; cfg_num_req = 16'd0;
    // Reset values
    do_reset();
    check("rst_awvalid", 64'(awvalid), 64'd0);
    check("rst_wvalid", 64'(wvalid), 64'd0);
    check("rst_wlast", 64'(wlast), 64'd0);
    check("rst_bready", 64'(bready), 64'd0);
    check("rst_wstrb", 64'(wstrb), 64'd0);
    check("rst_awaddr", 64'(awaddr), 64'd0);
    check("rst_wdata", 64'(wdata), 64'hACE1_0001);
    check("rst_ostd", 64'(ostd_cnt), 64'd0);
    check("rst_req", 64'(req_cnt), 64'd0);
    check("rst_resp", 64'(resp_cnt), 64'd0);
    check("rst_err", 64'(err_cnt), 64'd0);
    check("rst_done", 64'(done), 64'd0);

    // Single 4-beat burst
    cfg_len = 4'd3; cfg_size = 3'd2; cfg_num_req = 16'd1; start = 1'b1;
    check("aw_before_edge", 64'(awvalid), 64'd0);
    @(negedge aclk);
    check("aw_latency", 64'(awvalid), 64'd1);
    run(300, 1'b0, 1'b0, 1'b1);
    check("t1_req", 64'(req_cnt), 64'd1);
    check("t1_resp", 64'(resp_cnt), 64'd1);
    check("t1_ostd", 64'(ostd_cnt), 64'd0);
    check("t1_aw", 64'(aw_seen), 64'd1);
    check("t1_beats", 64'(beats_seen), 64'd4);
    check("t1_wdata_s4", 64'(wdata), 64'hBAE2_1003);
    check("t1_err", 64'(err_cnt), 64'd0);
    start = 1'b0;
    @(negedge aclk);
    check("stop_done", 64'(done), 64'd0);
    check("stop_req", 64'(req_cnt), 64'd0);
    check("stop_resp", 64'(resp_cnt), 64'd0);

    // Outstanding limit with B held, then release
    do_reset();
    cfg_len = 4'd3; cfg_size = 3'd2; cfg_num_req = 16'd8; start = 1'b1;
    run(40, 1'b0, 1'b1, 1'b0);
    check("t2_aw_held", 64'(aw_seen), 64'd4);
    check("t2_awvalid_low", 64'(awvalid), 64'd0);
    check("t2_ostd_full", 64'(ostd_cnt), 64'd4);
    run(600, 1'b0, 1'b0, 1'b1);
    check("t2_aw_all", 64'(aw_seen), 64'd8);
    check("t2_resp", 64'(resp_cnt), 64'd8);
    check("t2_beats", 64'(beats_seen), 64'd32);

    // Single-beat bursts: addresses 0,4,8 and wlast on every beat
    do_reset();
    cfg_len = 4'd0; cfg_size = 3'd2; cfg_num_req = 16'd3; start = 1'b1;
    run(300, 1'b0, 1'b0, 1'b1);
    check("t3_beats", 64'(beats_seen), 64'd3);
    check("t3_next_addr", 64'(awaddr), 64'd12);
    check("t3_wdata_s3", 64'(wdata), 64'h7584_2001);

    // Random wready stalls
    do_reset();
    cfg_len = 4'd3; cfg_size = 3'd2; cfg_num_req = 16'd4; start = 1'b1;
    run(800, 1'b1, 1'b0, 1'b1);
    check("t4_aw", 64'(aw_seen), 64'd4);
    check("t4_beats", 64'(beats_seen), 64'd16);
    check("t4_wdata_model", 64'(wdata), 64'(model_lfsr));

    // Bad bid then bad bresp
    do_reset();
    cfg_len = 4'd0; cfg_size = 3'd2; cfg_num_req = 16'd2; start = 1'b1;
    corrupt_q.push_back(1);
    corrupt_q.push_back(2);
    run(400, 1'b0, 1'b0, 1'b1);
    check("t5_resp", 64'(resp_cnt), 64'd2);
    check("t5_err", 64'(err_cnt), 64'(EXP_ERR));

    // Reset during beat 2 of a 4-beat burst
    do_reset();
    cfg_len = 4'd3; cfg_size = 3'd2; cfg_num_req = 16'd1; start = 1'b1;
    for (int k = 0; k < 20 && beats_seen < 1; k++) run(1, 1'b0, 1'b0, 1'b0);
    check("t6_first_beat", 64'(beats_seen), 64'd1);
    @(posedge aclk);
    #2;
    check("t6_midburst", 64'(wvalid), 64'd1);
    aresetn = 1'b0; start = 1'b0; bvalid = 1'b0;
    #1;
    check("t6_awvalid", 64'(awvalid), 64'd0);
    check("t6_wvalid", 64'(wvalid), 64'd0);
    check("t6_wlast", 64'(wlast), 64'd0);
    check("t6_wstrb", 64'(wstrb), 64'd0);
    check("t6_bready", 64'(bready), 64'd0);
    check("t6_ostd", 64'(ostd_cnt), 64'd0);
    check("t6_req", 64'(req_cnt), 64'd0);
    check("t6_wdata", 64'(wdata), 64'hACE1_0001);
    @(negedge aclk);
    aresetn = 1'b1;
    model_reset();
    start = 1'b1;
    run(300, 1'b0, 1'b0, 1'b1);
    check("t6_restart_beats", 64'(beats_seen), 64'd4);
    check("t6_restart_resp", 64'(resp_cnt), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_mst_wr_gen.md
# axi_mst_wr_gen

Parametrised AXI3 write-traffic master for crossbar verification and bring-up. It generates AW requests itself, streams matching W bursts with LFSR data, and tracks up to OSTD_NUM outstanding writes until their B responses return. It sits on one master port of the crossbar and replaces a passive W-only driver with a full AW/W/B generator. Every output is synthesisable and deterministic from LFSR_SEED.

## Interface
- AXI_ADDR_W, 32, address width
- AXI_ID_W, 4, ID width; must be ≥3
- AXI_DATA_W, 32, data width; multiple of 32
- OSTD_NUM, 4, max outstanding writes; power of 2, ≥2
- MST_ID, 2'b01, master tag placed in the top 2 ID bits
- BASE_ADDR, 0, address of the first burst
- LFSR_SEED, 32'hACE1_0001, data/bready LFSR seed; must be non-zero

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, asynchronous, active-low
- start  in  1  level enable; low aborts issue of new AW
- cfg_len  in  4  burst length − 1
- cfg_size  in  3  beat size; must be ≤ log2(AXI_DATA_W/8)
- cfg_num_req  in  16  number of bursts to issue
- awvalid/awready  out/in  1  AW handshake
- awaddr  out  AXI_ADDR_W  burst address
- awlen  out  4
- awsize  out  3
- awburst  out  2  constant 2'b01 (INCR)
- awid  out  AXI_ID_W
- awlock  out  2  constant 0
- wvalid/wready  out/in  1  W handshake
- wlast  out  1
- wid  out  AXI_ID_W
- wdata  out  AXI_DATA_W
- wstrb  out  AXI_DATA_W/8
- bvalid  in  1
- bready  out  1
- bid  in  AXI_ID_W
- bresp  in  2
- ostd_cnt  out  log2(OSTD_NUM)+1  current outstanding writes
- req_cnt  out  16  number of AW handshakes
- resp_cnt  out  16  number of B handshakes
- err_cnt  out  8  number of B check errors
- done  out  1  all requested bursts completed

## Operation
- AW issue: awvalid rises when start=1, req_cnt<cfg_num_req, ostd_cnt<OSTD_NUM, and the W queue is not full.
  - awaddr, awlen, awsize and awid are registered at launch and held stable until awready.
  - awvalid never drops without a handshake, even if start falls.
- awid = {MST_ID, seq}. seq is AXI_ID_W−2 bits, increments per AW handshake and wraps to 0.
- Address arithmetic: awaddr = BASE_ADDR + Σ of previous bursts' (len+1)<<size, accumulated modulo 2^AXI_ADDR_W.
- W queue: an OSTD_NUM-deep FIFO of {len,id}, pushed on the AW handshake. A same-cycle push and pop are both honoured.
- W channel:
  - wvalid = W queue not empty; wid = head id.
  - beat_cnt (4 bit) increments on each W handshake.
  - wlast = (beat_cnt == head len). The queue pops and beat_cnt clears on wlast&wready.
  - wstrb is all ones while wvalid, 0 otherwise.
- Data: 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1, advances once per W handshake.
  - wdata replicates the LFSR value AXI_DATA_W/32 times.
  - wdata is stable while wvalid&!wready.
- bready = LFSR bit 7, registered every cycle. It therefore toggles pseudo-randomly but deterministically.
- ostd_cnt: +1 on AW handshake, −1 on B handshake; unchanged when both occur in the same cycle.
- done = start & (req_cnt==cfg_num_req) & (ostd_cnt==0). start low clears done and zeroes req_cnt/resp_cnt on the next edge, but only once ostd_cnt==0.
- cfg_num_req=0 with start=1 gives done=1 and no traffic.

## Timing
- Reset values: all valid/ready/last outputs 0, awaddr=BASE_ADDR, LFSR=LFSR_SEED, all counters 0, done=0, FIFOs empty. wdata resets to LFSR_SEED replicated.
- Reset asserted mid-burst drops every valid at once and discards queue contents. No completion of the burst is attempted.
- awvalid: first asserted 1 cycle after start is sampled high.
- wvalid: earliest 1 cycle after the AW handshake, so W never leads AW.
- wlast is combinational from registered state and is valid in the same cycle as wvalid.
- Back-to-back bursts: wvalid stays high across the wlast→next-burst boundary when the queue holds more than one entry.
- Throughput: 1 AW per cycle while not throttled; 1 W beat per cycle under wready=1.

## Configuration
- AXI_MST_WR_GEN_BCHK_EN defined:
  - Adds an OSTD_NUM-deep expected-ID FIFO, pushed on the AW handshake and popped on the B handshake.
  - On each B handshake, bid≠head or bresp≠2'b00 increments err_cnt, saturating at 255.
  - A B handshake while the FIFO is empty also counts as an error.
- Undefined: the FIFO is omitted and err_cnt is tied to 0.

## Test plan
- cfg_len=3, cfg_size=2, cfg_num_req=1, awready/wready/bvalid always 1 → awaddr=0, awid=4'b0100, 4 beats, wlast on beat 4, done=1 after the B handshake.
- cfg_num_req=8, bvalid held 0 → exactly 4 AW handshakes, then awvalid stays 0 and ostd_cnt=4. Releasing B → remaining 4 issue; awid low bits wrap 0,1,2,3,0,1,2,3.
- cfg_len=0, cfg_size=2, cfg_num_req=3 → awaddr 0,4,8; each W beat has wlast=1; wdata sequence follows the LFSR from seed 32'hACE1_0001.
- wready toggled randomly → wdata and wid are held while stalled, beat counts match awlen+1, and there are no lost or duplicated LFSR values.
- With BCHK_EN, return bid=4'b0101 for the first response → err_cnt=1. Return bresp=2'b10 → err_cnt=2. Without the macro, err_cnt=0.
- aresetn pulsed low mid-burst (beat 2 of 4) → all outputs reach their reset values asynchronously, and the next start restarts from awaddr=BASE_ADDR.
